// File: rtl/prog_rom.sv
// prog_rom: synchronous program memory for the instruction-fetch path.
// It has a pipelined read port with a request/valid handshake and a read
// latency of 1 or 2. A streaming load port lets a boot source fill the
// memory one word at a time.
// Reads of addresses past DEPTH return FILL_VALUE. After reset, every
// entry also holds FILL_VALUE.
module prog_rom #(
    parameter int unsigned DATA_WIDTH   = 26,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned FILL_VALUE   = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         rd_req,
    output logic                         rd_ready,
    input  logic [ADDR_WIDTH-1:0]        ADDR,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        data,
    input  logic                         load_en,
    input  logic                         load_valid,
    output logic                         load_ready,
    input  logic [DATA_WIDTH-1:0]        load_data,
    output logic                         load_done,
    output logic [$clog2(DEPTH+1)-1:0]   load_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [DATA_WIDTH-1:0] FILL     = DATA_WIDTH'(FILL_VALUE);
    localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    load_state_t             state;
    load_state_t             state_d;
    logic [PTR_W-1:0]        ptr;
    logic [PTR_W-1:0]        ptr_d;
    logic [CNT_W-1:0]        count_d;
    logic                    wr_en;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    rd_accept;
    logic                    addr_hit;
    logic [DATA_WIDTH-1:0]   rd_word;

    // Handshake flags are decoded straight from the state register
    assign load_ready = (state == LOAD);
    assign load_done  = (state == DONE);
    assign rd_ready   = (state != LOAD);

    // Load FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Load FSM next state, write strobe, pointer and count updates
    always_comb begin
        state_d = state;
        ptr_d   = ptr;
        count_d = load_count;
        wr_en   = 1'b0;
        case (state)
            IDLE: begin
                if (load_en) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                    count_d = '0;
                end
            end
            LOAD: begin
                if (!load_en) begin
                    // Abort: words already written stay, the beat in this cycle is dropped
                    state_d = IDLE;
                    count_d = '0;
                end else if (load_valid) begin
                    wr_en = 1'b1;
                    if (ptr == LAST_PTR) begin
                        // Pointer parks on the last entry; count saturates at DEPTH
                        state_d = DONE;
                        count_d = FULL_CNT;
                    end else begin
                        ptr_d   = ptr + PTR_W'(1);
                        count_d = load_count + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                count_d = FULL_CNT;
                if (!load_en) begin
                    state_d = IDLE;
                    count_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // Load pointer and word counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= '0;
            load_count <= '0;
        end else begin
            ptr        <= ptr_d;
            load_count <= count_d;
        end
    end

    // Storage array; reset restores the fill pattern in every entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= FILL;
            end
        end else if (wr_en) begin
            mem[ptr] <= load_data;
        end
    end

    // Read fetch: out-of-range addresses return the fill value
    always_comb begin
        rd_accept = rd_req && rd_ready;
        addr_hit  = ({1'b0, ADDR} < (ADDR_WIDTH + 1)'(DEPTH));
        rd_word   = FILL;
        if (addr_hit) begin
            rd_word = mem[ADDR[PTR_W-1:0]];
        end
    end

    if (READ_LATENCY == 1) begin : g_lat1

        // Single-stage read: data and valid register at the accepting edge
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_valid <= 1'b0;
                data     <= FILL;
            end else begin
                rd_valid <= rd_accept;
                if (rd_accept) begin
                    data <= rd_word;
                end
            end
        end

    end else begin : g_lat2

        logic                  s1_valid;
        logic [DATA_WIDTH-1:0] s1_word;

        // Two-stage read: fetched word passes one extra register before data
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                s1_valid <= 1'b0;
                s1_word  <= FILL;
                rd_valid <= 1'b0;
                data     <= FILL;
            end else begin
                s1_valid <= rd_accept;
                if (rd_accept) begin
                    s1_word <= rd_word;
                end
                rd_valid <= s1_valid;
                if (s1_valid) begin
                    data <= s1_word;
                end
            end
        end

    end

endmodule

// File: tb/tb_prog_rom.sv
// Testbench for prog_rom. It drives one latency-1 and one latency-2 instance
// from shared inputs. Expected read words go into a scoreboard with their due cycle.
// Load handshake outputs are compared every cycle against a small reference model.
module tb_prog_rom;

    localparam int unsigned DW    = 26;
    localparam int unsigned AW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CW    = 5;
    localparam logic [DW-1:0] FILL = 26'd8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] addr = '0;
    logic          load_en = 1'b0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;

    logic          rd_ready1, rd_valid1, load_ready1, load_done1;
    logic [DW-1:0] data1;
    logic [CW-1:0] load_count1;
    logic          rd_ready2, rd_valid2, load_ready2, load_done2;
    logic [DW-1:0] data2;
    logic [CW-1:0] load_count2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [DW-1:0] d;
        int            due;
    } sb_t;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] exp;
    } vec_t;

    sb_t           q1[$];
    sb_t           q2[$];
    logic [DW-1:0] last1 = 26'd8;
    logic [DW-1:0] last2 = 26'd8;
    vec_t          vt[5];

    typedef enum {M_IDLE, M_LOAD, M_DONE} mst_t;
    mst_t m_st  = M_IDLE;
    int   m_cnt = 0;

    prog_rom #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FILL_VALUE(8), .READ_LATENCY(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_ready(rd_ready1), .ADDR(addr),
        .rd_valid(rd_valid1), .data(data1), .load_en(load_en), .load_valid(load_valid),
        .load_ready(load_ready1), .load_data(load_data), .load_done(load_done1),
        .load_count(load_count1)
    );

    prog_rom #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .FILL_VALUE(8), .READ_LATENCY(2)) u_lat2 (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .rd_ready(rd_ready2), .ADDR(addr),
        .rd_valid(rd_valid2), .data(data2), .load_en(load_en), .load_valid(load_valid),
        .load_ready(load_ready2), .load_data(load_data), .load_done(load_done2),
        .load_count(load_count2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model of the load session
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st  <= M_IDLE;
            m_cnt <= 0;
        end else begin
            case (m_st)
                M_IDLE: if (load_en) begin m_st <= M_LOAD; m_cnt <= 0; end
                M_LOAD: begin
                    if (!load_en) begin
                        m_st  <= M_IDLE;
                        m_cnt <= 0;
                    end else if (load_valid) begin
                        m_cnt <= m_cnt + 1;
                        if (m_cnt + 1 == DEPTH) m_st <= M_DONE;
                    end
                end
                default: if (!load_en) begin m_st <= M_IDLE; m_cnt <= 0; end
            endcase
        end
    end

    // Reset flushes in-flight expectations and the held-data reference
    always @(negedge rst_n) begin
        q1.delete();
        q2.delete();
        last1 = FILL;
        last2 = FILL;
    end

    // Per-cycle output checks, sampled on the falling edge
    always @(negedge clk) begin
        sb_t e;
        check("load_ready1", 32'(load_ready1), 32'(m_st == M_LOAD));
        check("load_done1",  32'(load_done1),  32'(m_st == M_DONE));
        check("load_count1", 32'(load_count1), 32'(m_cnt));
        check("rd_ready1",   32'(rd_ready1),   32'(m_st != M_LOAD));
        check("load_count2", 32'(load_count2), 32'(m_cnt));
        check("rd_ready2",   32'(rd_ready2),   32'(m_st != M_LOAD));
        if (rd_valid1) begin
            if (q1.size() == 0) begin
                check("spurious rd_valid1", 32'(rd_valid1), 32'(0));
            end else begin
                e = q1.pop_front();
                check("data1", 32'(data1), 32'(e.d));
                check("latency1 cycle", 32'(cyc), 32'(e.due));
                last1 = e.d;
            end
        end else begin
            check("hold data1", 32'(data1), 32'(last1));
        end
        if (rd_valid2) begin
            if (q2.size() == 0) begin
                check("spurious rd_valid2", 32'(rd_valid2), 32'(0));
            end else begin
                e = q2.pop_front();
                check("data2", 32'(data2), 32'(e.d));
                check("latency2 cycle", 32'(cyc), 32'(e.due));
                last2 = e.d;
            end
        end else begin
            check("hold data2", 32'(data2), 32'(last2));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_beat(input logic [AW-1:0] a, input logic [DW-1:0] e);
        sb_t s;
        rd_req = 1'b1;
        addr   = a;
        s.d    = e;
        s.due  = cyc + 1;
        q1.push_back(s);
        s.due  = cyc + 2;
        q2.push_back(s);
        tick();
    endtask

    task automatic idle(input int n);
        rd_req = 1'b0;
        repeat (n) tick();
    endtask

    task automatic ld_beat(input logic v, input logic [DW-1:0] d);
        load_en    = 1'b1;
        load_valid = v;
        load_data  = d;
        tick();
    endtask

    task automatic start_load();
        load_en    = 1'b1;
        load_valid = 1'b0;
        tick();
    endtask

    task automatic end_load();
        load_en    = 1'b0;
        load_valid = 1'b0;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{a: 16'h0000, exp: 26'd8};
        vt[1] = '{a: 16'h0005, exp: 26'd8};
        vt[2] = '{a: 16'h000F, exp: 26'd8};
        vt[3] = '{a: 16'h0010, exp: 26'd8};
        vt[4] = '{a: 16'hFFFF, exp: 26'd8};

        repeat (2) tick();
        check("reset data1",       32'(data1),       32'(FILL));
        check("reset data2",       32'(data2),       32'(FILL));
        check("reset rd_valid1",   32'(rd_valid1),   32'(0));
        check("reset load_count1", 32'(load_count1), 32'(0));
        rst_n = 1'b1;
        tick();

        // Reset contents, including out-of-range addresses
        for (int i = 0; i < 5; i++) rd_beat(vt[i].a, vt[i].exp);
        idle(4);

        // Continuous load, then back-to-back reads
        start_load();
        for (int i = 0; i < DEPTH; i++) ld_beat(1'b1, DW'(32'h100 + i));
        check("full load_done1",  32'(load_done1),  32'(1));
        check("full load_count1", 32'(load_count1), 32'(16));
        check("full load_ready1", 32'(load_ready1), 32'(0));
        load_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) rd_beat(AW'(i), DW'(32'h100 + i));
        idle(4);
        end_load();
        check("exit load_done1",  32'(load_done1),  32'(0));
        check("exit load_count1", 32'(load_count1), 32'(0));

        // Gapped load
        start_load();
        for (int k = 0; k < DEPTH; k++) begin
            ld_beat(1'b1, DW'(32'h200 + k));
            if (k == 7) check("gapped load_count1", 32'(load_count1), 32'(8));
            ld_beat(1'b0, 26'h3FF_FFFF);
        end
        end_load();
        for (int i = 0; i < DEPTH; i++) rd_beat(AW'(i), DW'(32'h200 + i));
        idle(4);

        // Abort after five beats; the abort-cycle beat is dropped
        start_load();
        for (int i = 0; i < 5; i++) ld_beat(1'b1, DW'(32'h300 + i));
        load_en    = 1'b0;
        load_valid = 1'b1;
        load_data  = 26'hBAD;
        tick();
        load_valid = 1'b0;
        check("abort load_count1", 32'(load_count1), 32'(0));
        check("abort load_ready1", 32'(load_ready1), 32'(0));
        for (int i = 0; i < DEPTH; i++)
            rd_beat(AW'(i), (i < 5) ? DW'(32'h300 + i) : DW'(32'h200 + i));
        idle(4);

        // Read accepted on the edge that starts LOAD, then a request held through LOAD
        load_en    = 1'b1;
        load_valid = 1'b0;
        rd_beat(16'd3, 26'h303);
        addr = 16'd7;
        for (int i = 0; i < DEPTH; i++) ld_beat(1'b1, DW'(32'h400 + i));
        load_valid = 1'b0;
        rd_beat(16'd7, 26'h407);
        idle(4);
        end_load();

        // Asynchronous reset in the middle of a load
        start_load();
        for (int i = 0; i < 7; i++) ld_beat(1'b1, DW'(32'h500 + i));
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst load_ready1", 32'(load_ready1), 32'(0));
        check("midrst load_count1", 32'(load_count1), 32'(0));
        check("midrst rd_ready1",   32'(rd_ready1),   32'(1));
        check("midrst data1",       32'(data1),       32'(FILL));
        check("midrst data2",       32'(data2),       32'(FILL));
        load_en    = 1'b0;
        load_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < DEPTH; i++) rd_beat(AW'(i), FILL);
        idle(4);

        // Fresh session after reset fills from entry 0
        start_load();
        for (int i = 0; i < DEPTH; i++) ld_beat(1'b1, DW'(32'h600 + i));
        check("reload load_count1", 32'(load_count1), 32'(16));
        end_load();
        for (int i = 0; i < DEPTH; i++) rd_beat(AW'(i), DW'(32'h600 + i));
        rd_beat(16'd16, FILL);
        idle(5);

        check("scoreboard1 drained", 32'(q1.size()), 32'(0));
        check("scoreboard2 drained", 32'(q2.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
